// File: rtl/nrzi_encode_tx_pkg.sv
// Shared USB line definitions for the NRZI transmit encoder: FSM encodings,
// differential line constants and the J/K toggle used by NRZI coding.
package nrzi_encode_tx_pkg;

  typedef logic [1:0] state_t;
  typedef logic [1:0] line_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_DATA    = 2'd1;
  localparam state_t ST_EOP_SE0 = 2'd2;
  localparam state_t ST_EOP_J   = 2'd3;

  // Line values are packed as {dp, dm}.
  localparam line_t LINE_J   = 2'b10;
  localparam line_t LINE_K   = 2'b01;
  localparam line_t LINE_SE0 = 2'b00;

  function automatic line_t line_toggle(input line_t level);
    return (level == LINE_J) ? LINE_K : LINE_J;
  endfunction

endpackage

// File: rtl/nrzi_encode_tx_if.sv
// Handshake and line-side signals of the NRZI transmit encoder.
// The serializer/pad side uses master; the encoder uses slave.
interface nrzi_encode_tx_if;

  logic start_txd;
  logic tx_data_in;
  logic tx_data_valid;
  logic tx_last;
  logic tx_ready;
  logic tx_dp;
  logic tx_dm;
  logic tx_oe;
  logic tx_busy;
  logic tx_done;
  logic tx_error;

  modport master (
    output start_txd, tx_data_in, tx_data_valid, tx_last,
    input  tx_ready, tx_dp, tx_dm, tx_oe, tx_busy, tx_done, tx_error
  );

  modport slave (
    input  start_txd, tx_data_in, tx_data_valid, tx_last,
    output tx_ready, tx_dp, tx_dm, tx_oe, tx_busy, tx_done, tx_error
  );

endinterface

// File: rtl/nrzi_encode_tx_bit_timer.sv
// Line bit timer: counts CLKS_PER_BIT system clocks per line bit and strobes
// on count zero. Held at zero while clear is asserted.
module nrzi_encode_tx_bit_timer #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic gclk,
  input  logic reset_l,
  input  logic clear,
  output logic strobe
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge gclk or negedge reset_l) begin
    if (!reset_l) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign strobe = (cnt_q == '0);

endmodule

// File: rtl/nrzi_encode_tx.sv
// USB full-speed transmit encoder: bit stuffing, NRZI line coding and EOP
// generation between the packet serializer and the transceiver pads.
module nrzi_encode_tx
  import nrzi_encode_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1,
  parameter int STUFF_LEN    = 6,
  parameter int EOP_SE0_BITS = 2
) (
  input  logic gclk,
  input  logic reset_l,
  nrzi_encode_tx_if.slave bus
);

  localparam int EOP_W = $clog2(EOP_SE0_BITS + 1);
  localparam logic [2:0]       ONES_MAX = 3'(STUFF_LEN);
  localparam logic [EOP_W-1:0] EOP_MAX  = EOP_W'(EOP_SE0_BITS);

  state_t           state_q, state_d;
  line_t            line_q, line_d;
  logic             oe_q, oe_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic             last_q, last_d;
  logic [2:0]       ones_q, ones_d;
  logic [EOP_W-1:0] eop_q, eop_d;
  logic             idle;
  logic             strobe;
  logic             ready;

  assign idle = (state_q == ST_IDLE);

  nrzi_encode_tx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .gclk    (gclk),
    .reset_l (reset_l),
    .clear   (idle),
    .strobe  (strobe)
  );

  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    oe_d    = oe_q;
    done_d  = 1'b0;
    error_d = 1'b0;
    last_d  = last_q;
    ones_d  = ones_q;
    eop_d   = eop_q;
    ready   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        line_d = LINE_J;
        oe_d   = 1'b0;
        ones_d = '0;
        last_d = 1'b0;
        eop_d  = '0;
        if (bus.start_txd) begin
          state_d = ST_DATA;
          oe_d    = 1'b1;
        end
      end

      // Stuffing outranks EOP so a trailing run of ones is still broken up.
      ST_DATA: begin
        if (strobe) begin
          if (ones_q == ONES_MAX) begin
            line_d = line_toggle(line_q);
            ones_d = '0;
          end else if (last_q) begin
            state_d = ST_EOP_SE0;
            line_d  = LINE_SE0;
            eop_d   = EOP_W'(1);
          end else begin
            ready = 1'b1;
            if (bus.tx_data_valid) begin
              if (bus.tx_data_in) begin
                ones_d = ones_q + 3'd1;
              end else begin
                line_d = line_toggle(line_q);
                ones_d = '0;
              end
              if (bus.tx_last) begin
                last_d = 1'b1;
              end
            end else begin
              error_d = 1'b1;
              state_d = ST_EOP_SE0;
              line_d  = LINE_SE0;
              eop_d   = EOP_W'(1);
            end
          end
        end
      end

      ST_EOP_SE0: begin
        if (strobe) begin
          if (eop_q == EOP_MAX) begin
            state_d = ST_EOP_J;
            line_d  = LINE_J;
          end else begin
            eop_d = eop_q + EOP_W'(1);
          end
        end
      end

      ST_EOP_J: begin
        if (strobe) begin
          state_d = ST_IDLE;
          oe_d    = 1'b0;
          done_d  = 1'b1;
          line_d  = LINE_J;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge gclk or negedge reset_l) begin
    if (!reset_l) begin
      state_q <= ST_IDLE;
      line_q  <= LINE_J;
      oe_q    <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      last_q  <= 1'b0;
      ones_q  <= '0;
      eop_q   <= '0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      oe_q    <= oe_d;
      done_q  <= done_d;
      error_q <= error_d;
      last_q  <= last_d;
      ones_q  <= ones_d;
      eop_q   <= eop_d;
    end
  end

  assign bus.tx_ready = ready;
  assign bus.tx_dp    = line_q[1];
  assign bus.tx_dm    = line_q[0];
  assign bus.tx_oe    = oe_q;
  assign bus.tx_busy  = ~idle;
  assign bus.tx_done  = done_q;
  assign bus.tx_error = error_q;

endmodule

// File: tb/tb_nrzi_encode_tx.sv
// Self-checking bench for nrzi_encode_tx: one instance at one clock per bit,
// one at four clocks per bit, checked against a bit-period reference model.
module tb_nrzi_encode_tx;

  localparam int STUFF = 6;
  localparam logic [1:0] J   = 2'b10;
  localparam logic [1:0] K   = 2'b01;
  localparam logic [1:0] SE0 = 2'b00;

  logic gclk    = 1'b0;
  logic reset_l = 1'b1;
  logic din     = 1'b0;
  logic valid   = 1'b0;
  logic last    = 1'b0;
  logic start1  = 1'b0;
  logic start4  = 1'b0;
  bit   cur_sel = 1'b0;

  int vectors     = 0;
  int miscompares = 0;

  bit         pkt_bits [0:63];
  logic [1:0] exp_sym[$];
  int         exp_rdy[$];

  always #5 gclk = ~gclk;

  nrzi_encode_tx_if bus1 ();
  nrzi_encode_tx_if bus4 ();

  assign bus1.start_txd     = start1;
  assign bus1.tx_data_in    = din;
  assign bus1.tx_data_valid = valid;
  assign bus1.tx_last       = last;
  assign bus4.start_txd     = start4;
  assign bus4.tx_data_in    = din;
  assign bus4.tx_data_valid = valid;
  assign bus4.tx_last       = last;

  nrzi_encode_tx #(.CLKS_PER_BIT(1), .STUFF_LEN(STUFF), .EOP_SE0_BITS(2)) dut1 (
    .gclk    (gclk),
    .reset_l (reset_l),
    .bus     (bus1)
  );

  nrzi_encode_tx #(.CLKS_PER_BIT(4), .STUFF_LEN(STUFF), .EOP_SE0_BITS(2)) dut4 (
    .gclk    (gclk),
    .reset_l (reset_l),
    .bus     (bus4)
  );

  logic o_dp, o_dm, o_oe, o_busy, o_ready, o_done, o_err;
  assign o_dp    = cur_sel ? bus4.tx_dp    : bus1.tx_dp;
  assign o_dm    = cur_sel ? bus4.tx_dm    : bus1.tx_dm;
  assign o_oe    = cur_sel ? bus4.tx_oe    : bus1.tx_oe;
  assign o_busy  = cur_sel ? bus4.tx_busy  : bus1.tx_busy;
  assign o_ready = cur_sel ? bus4.tx_ready : bus1.tx_ready;
  assign o_done  = cur_sel ? bus4.tx_done  : bus1.tx_done;
  assign o_err   = cur_sel ? bus4.tx_error : bus1.tx_error;

  task automatic drive_start(input bit sel, input logic v);
    if (sel) start4 = v;
    else     start1 = v;
  endtask

  // Reference: walks the packet bit by bit, producing line symbols per bit
  // slot and the slots at which the encoder should ask for data.
  task automatic build_model(input int n, input int under);
    logic [1:0] lvl;
    int ones;
    int slot;
    exp_sym.delete();
    exp_rdy.delete();
    lvl  = J;
    ones = 0;
    slot = 0;
    for (int i = 0; i < n; i++) begin
      exp_rdy.push_back(slot);
      if (i == under) break;
      slot++;
      if (pkt_bits[i]) begin
        ones++;
      end else begin
        ones = 0;
        lvl  = ~lvl;
      end
      exp_sym.push_back(lvl);
      if (ones == STUFF) begin
        lvl  = ~lvl;
        ones = 0;
        exp_sym.push_back(lvl);
        slot++;
      end
    end
    exp_sym.push_back(SE0);
    exp_sym.push_back(SE0);
    exp_sym.push_back(J);
  endtask

  task automatic run_packet(input bit sel, input int n, input int under,
                            input int busy_start, input string name);
    int cpb;
    int budget;
    int idx;
    int dones;
    int errs;
    int busy_gaps;
    int exp_errs;
    bit pend;
    bit finished;
    logic [1:0] trace[$];
    logic [1:0] want[$];
    int rdy[$];

    cpb = sel ? 4 : 1;
    cur_sel = sel;
    build_model(n, under);
    want.push_back(J);
    foreach (exp_sym[k]) repeat (cpb) want.push_back(exp_sym[k]);
    budget    = 40 + 2 * want.size();
    idx       = 0;
    dones     = 0;
    errs      = 0;
    busy_gaps = 0;
    pend      = 1'b0;
    finished  = 1'b0;
    exp_errs  = (under >= 0 && under < n) ? 1 : 0;

    @(negedge gclk);
    drive_start(sel, 1'b1);
    for (int cyc = 0; cyc < budget && !finished; cyc++) begin
      @(negedge gclk);
      drive_start(sel, cyc == busy_start);
      if (pend) begin
        idx++;
        pend = 1'b0;
      end
      if (o_done) begin
        finished = 1'b1;
        dones++;
        vectors++;
        if (o_oe !== 1'b0 || o_busy !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL %s idle_at_done: got oe=%b busy=%b expected oe=0 busy=0", name, o_oe, o_busy);
        end
      end else if (o_busy !== 1'b1) begin
        busy_gaps++;
      end
      if (o_oe) trace.push_back({o_dp, o_dm});
      if (o_err) errs++;
      if (o_ready) begin
        rdy.push_back(cyc);
        if (idx < n && idx != under) begin
          valid = 1'b1;
          din   = pkt_bits[idx];
          last  = (idx == n - 1);
          pend  = 1'b1;
        end else begin
          valid = 1'b0;
          din   = 1'($urandom);
          last  = 1'($urandom);
        end
      end else begin
        valid = 1'($urandom);
        din   = 1'($urandom);
        last  = 1'($urandom);
      end
    end
    drive_start(sel, 1'b0);
    valid = 1'b0;
    last  = 1'b0;

    vectors++;
    if (!finished) begin
      miscompares++;
      $display("[TB] FAIL %s timeout: got no done within %0d cycles expected done", name, budget);
    end
    repeat (2) begin
      @(negedge gclk);
      if (o_done) dones++;
    end

    vectors++;
    if (busy_gaps != 0) begin
      miscompares++;
      $display("[TB] FAIL %s busy: got %0d idle cycles expected 0", name, busy_gaps);
    end
    vectors++;
    if (trace.size() != want.size()) begin
      miscompares++;
      $display("[TB] FAIL %s line_len: got %0d cycles expected %0d", name, trace.size(), want.size());
    end
    for (int i = 0; i < want.size(); i++) begin
      if (i < trace.size()) begin
        vectors++;
        if (trace[i] !== want[i]) begin
          miscompares++;
          $display("[TB] FAIL %s line[%0d]: got dp,dm=%b expected %b", name, i, trace[i], want[i]);
        end
      end
    end
    vectors++;
    if (rdy.size() != exp_rdy.size()) begin
      miscompares++;
      $display("[TB] FAIL %s ready_count: got %0d expected %0d", name, rdy.size(), exp_rdy.size());
    end
    for (int i = 0; i < exp_rdy.size(); i++) begin
      if (i < rdy.size()) begin
        vectors++;
        if (rdy[i] != exp_rdy[i] * cpb) begin
          miscompares++;
          $display("[TB] FAIL %s ready_cycle[%0d]: got %0d expected %0d", name, i, rdy[i], exp_rdy[i] * cpb);
        end
      end
    end
    vectors++;
    if (dones != 1) begin
      miscompares++;
      $display("[TB] FAIL %s done_count: got %0d expected 1", name, dones);
    end
    vectors++;
    if (errs != exp_errs) begin
      miscompares++;
      $display("[TB] FAIL %s error_count: got %0d expected %0d", name, errs, exp_errs);
    end
  endtask

  task automatic test_reset();
    #3 reset_l = 1'b0;
    #4;
    for (int s = 0; s < 2; s++) begin
      cur_sel = s[0];
      #1;
      vectors++;
      if ({o_dp, o_dm, o_oe, o_ready, o_busy, o_done, o_err} !== 7'b1000000) begin
        miscompares++;
        $display("[TB] FAIL reset_hold[%0d]: got %b expected 1000000", s, {o_dp, o_dm, o_oe, o_ready, o_busy, o_done, o_err});
      end
    end
    @(negedge gclk);
    reset_l = 1'b1;
    repeat (3) @(negedge gclk);
    for (int s = 0; s < 2; s++) begin
      cur_sel = s[0];
      #1;
      vectors++;
      if ({o_dp, o_dm, o_oe, o_ready, o_busy, o_done, o_err} !== 7'b1000000) begin
        miscompares++;
        $display("[TB] FAIL reset_release[%0d]: got %b expected 1000000", s, {o_dp, o_dm, o_oe, o_ready, o_busy, o_done, o_err});
      end
    end
  endtask

  task automatic load_bits(input int n, input logic [31:0] pattern);
    for (int i = 0; i < n; i++) pkt_bits[i] = pattern[i];
  endtask

  task automatic test_byte_0x80();
    load_bits(8, 32'h80);
    run_packet(1'b0, 8, -1, -1, "byte80");
  endtask

  task automatic test_stuff_seven();
    load_bits(7, 32'h7f);
    run_packet(1'b0, 7, -1, -1, "seven_ones");
  endtask

  task automatic test_stuff_before_eop();
    load_bits(6, 32'h3f);
    run_packet(1'b0, 6, -1, -1, "six_ones");
  endtask

  task automatic test_underrun();
    for (int i = 0; i < 10; i++) pkt_bits[i] = 1'($urandom);
    run_packet(1'b0, 10, 3, -1, "underrun");
  endtask

  task automatic test_clks4();
    load_bits(8, 32'h80);
    run_packet(1'b1, 8, -1, 2, "cpb4_byte80");
    load_bits(7, 32'h7f);
    run_packet(1'b1, 7, -1, 5, "cpb4_seven_ones");
    for (int i = 0; i < 8; i++) pkt_bits[i] = 1'($urandom);
    run_packet(1'b1, 8, 3, -1, "cpb4_underrun");
  endtask

  task automatic test_random();
    int n;
    int under;
    int bstart;
    for (int p = 0; p < 8; p++) begin
      n = $urandom_range(1, 24);
      for (int i = 0; i < n; i++) pkt_bits[i] = ($urandom_range(0, 3) != 0);
      under  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
      bstart = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 6) : -1;
      run_packet(p[0], n, under, bstart, "random");
    end
  endtask

  task automatic test_back_to_back();
    load_bits(8, 32'h5a);
    run_packet(1'b0, 8, -1, -1, "b2b_first");
    load_bits(9, 32'h1fe);
    run_packet(1'b0, 9, -1, -1, "b2b_second");
  endtask

  task automatic test_reset_mid();
    int dones;
    int bad;
    cur_sel = 1'b1;
    @(negedge gclk);
    start4 = 1'b1;
    valid  = 1'b1;
    last   = 1'b0;
    repeat (10) begin
      @(negedge gclk);
      start4 = 1'b0;
      din    = 1'($urandom);
    end
    vectors++;
    if (o_busy !== 1'b1 || o_oe !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL mid_active: got busy=%b oe=%b expected 1 1", o_busy, o_oe);
    end
    @(posedge gclk);
    #2 reset_l = 1'b0;
    #1;
    vectors++;
    if ({o_dp, o_dm, o_oe, o_busy, o_ready} !== 5'b10000) begin
      miscompares++;
      $display("[TB] FAIL mid_reset: got %b expected 10000", {o_dp, o_dm, o_oe, o_busy, o_ready});
    end
    repeat (2) @(negedge gclk);
    reset_l = 1'b1;
    valid   = 1'b0;
    dones   = 0;
    bad     = 0;
    repeat (20) begin
      @(negedge gclk);
      if (o_done) dones++;
      if ({o_dp, o_dm, o_oe, o_busy} !== 4'b1000) bad++;
    end
    vectors++;
    if (dones != 0) begin
      miscompares++;
      $display("[TB] FAIL mid_no_done: got %0d expected 0", dones);
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("[TB] FAIL mid_idle_line: got %0d bad cycles expected 0", bad);
    end
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_byte_0x80();
    test_stuff_seven();
    test_stuff_before_eop();
    test_underrun();
    test_back_to_back();
    test_clks4();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
